multitap_letter_fsm: RTL and testbench
======================================

Name: multitap_letter_fsm

Overview:
- Sits directly downstream of the keypad scan controller and consumes its `cur_key` / `strobe` pair.
- Turns 4x4 keypad presses into uppercase ASCII letters for the Hangman guess path, using phone-style multi-tap entry (repeat a key to cycle its letters).
- `#` submits the letter, `*` cancels it, and an optional idle timeout auto-submits.
- Committed letters go to the message/transmit logic.

Parameters:
- TIMEOUT, 0, idle cycles after the last accepted letter key before auto-commit; 0 disables auto-commit.
- CNT_W, 24, width of the idle counter; the integrator sets CNT_W so that TIMEOUT fits in CNT_W bits.

Ports:
- clk  input  1  system clock.
- nRst  input  1  asynchronous, active-low reset.
- strobe  input  1  single-cycle key-press event from the scan controller.
- cur_key  input  8  key code: [7:4] one-hot row, [3:0] one-hot column, both active high.
- cand_char  output  8  ASCII of the letter being composed; 8'h00 when none.
- cand_valid  output  1  high while a candidate is held (state CYCLE).
- commit_char  output  8  last committed ASCII letter; holds until the next commit.
- commit_pulse  output  1  one-cycle pulse, asserted in the same cycle commit_char updates.
- clear_pulse  output  1  one-cycle pulse on `*`.
- bad_key  output  1  one-cycle pulse on an unusable key or code.

Behaviour:
- Key map. Row [7] is the top row; column [3] is the left column.
  - Top row: 88='1', 84='2', 82='3', 81='A'.
  - Second row: 48='4', 44='5', 42='6', 41='B'.
  - Third row: 28='7', 24='8', 22='9', 21='C'.
  - Bottom row: 18='*', 14='0', 12='#', 11='D'.
  - Any code that is not exactly one row bit plus one column bit is invalid.
- Letter groups:
  - 2=ABC, 3=DEF, 4=GHI, 5=JKL, 6=MNO, 7=PQRS, 8=TUV, 9=WXYZ.
  - Group size is 4 for keys 7 and 9, 3 otherwise.
  - cand_char = base(key) + idx, where idx is 2 bits.
- Sampling and latency:
  - cur_key is decoded only in cycles where strobe=1.
  - All outputs are registered; a response appears on the clock edge that samples strobe, i.e. visible the following cycle.
  - cur_key is ignored whenever strobe=0.
- States: IDLE and CYCLE. Registered state holds held_key[3:0], idx[1:0] and idle_cnt.
- Letter key (2-9), from IDLE or with a key different from held_key:
  - held_key <= key, idx <= 0, state becomes CYCLE, idle_cnt <= 0.
  - A different key discards the previous candidate without committing it.
- Same letter key in CYCLE:
  - idx <= idx+1, wrapping to 0 after the last letter of the group; idle_cnt <= 0.
- `#` in CYCLE:
  - commit_char <= cand_char and commit_pulse=1.
  - Then go to IDLE with cand_char=0 and cand_valid=0.
- `#` in IDLE: bad_key=1; no other change.
- `*` in any state: go to IDLE, clear the candidate, clear_pulse=1. commit_char is unchanged.
- Keys 1, 0, A-D and invalid codes: bad_key=1; state, candidate and counter are unchanged.
- Idle counter:
  - Applies only when TIMEOUT>0 and state is CYCLE.
  - idle_cnt increments every cycle without a strobe.
  - When idle_cnt==TIMEOUT-1 and strobe=0: auto-commit, identical to `#`, and idle_cnt <= 0.
  - If strobe=1 in the same cycle as the terminal count, the key is processed and no auto-commit occurs.
  - In IDLE, idle_cnt is held at 0.
- Pulses: commit_pulse, clear_pulse and bad_key are never asserted for more than one cycle per strobe or timeout event. At most one of them is high in any cycle.
- Reset (asynchronous, including mid-composition):
  - State becomes IDLE; held_key, idx and idle_cnt go to 0.
  - All outputs go to 0, including commit_char.
  - Nothing is committed by reset.
- A strobe arriving in the first cycle after reset release is processed normally.

Test Plan:
- Strobe 8'h84, then 8'h12 → after the first press cand_char=8'h41, cand_valid=1; after `#` commit_char=8'h41, commit_pulse high for exactly 1 cycle, cand_valid=0.
- Strobe 8'h28 five times, then 8'h12 → cand_char sequence 50,51,52,53,50 (wrap); commit_char=8'h50.
- Strobe 8'h84, then 8'h82, then 8'h18 → cand_char 41 then 44 (no commit on key change); after `*` clear_pulse=1, cand_char=00, commit_pulse never asserted.
- Each of the following is a separate stimulus, applied in both IDLE and CYCLE:
  - 8'h12 in IDLE → bad_key=1, commit_pulse stays 0.
  - 8'hC4 → bad_key=1, state, cand_char, idx and idle_cnt unchanged.
  - 8'h14 → bad_key=1, state, cand_char, idx and idle_cnt unchanged.
- TIMEOUT=16: strobe 8'h22 twice → cand_char=8'h58; with no further strobe, commit_pulse fires 16 cycles after the second strobe with commit_char=8'h58. Repeat with a strobe on the terminal cycle → no auto-commit.
- Strobe 8'h44 twice, assert nRst low mid-cycle → all outputs 0 immediately. After release, strobe 8'h44 → cand_char=8'h4A (index restarted).

Source files
------------

// File: rtl/multitap_letter_fsm.sv
// multitap_letter_fsm: phone-style multi-tap keypad-to-ASCII letter entry.
// Ports:
//   clk          system clock
//   nRst         asynchronous active-low reset
//   strobe       single-cycle key-press event; cur_key is decoded only when high
//   cur_key      key code, [7:4] one-hot row (bit 7 = top), [3:0] one-hot column (bit 3 = left)
//   cand_char    ASCII of the letter being composed, 8'h00 when none
//   cand_valid   high while a candidate is held
//   commit_char  last committed letter, held until the next commit
//   commit_pulse one-cycle pulse when commit_char updates
//   clear_pulse  one-cycle pulse on '*'
//   bad_key      one-cycle pulse on an unusable key or malformed code
module multitap_letter_fsm #(
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 24
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       strobe,
  input  logic [7:0] cur_key,
  output logic [7:0] cand_char,
  output logic       cand_valid,
  output logic [7:0] commit_char,
  output logic       commit_pulse,
  output logic       clear_pulse,
  output logic       bad_key
);
  typedef enum logic {IDLE, CYCLE} state_t;
  localparam bit TIMED = TIMEOUT > 0;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state, state_n;
  logic [3:0] held_key, held_n;
  logic [1:0] idx, idx_n, last;
  logic [CNT_W-1:0] idle_cnt, cnt_n;
  logic [7:0] cand_n, commit_n;
  logic cp_n, clr_n, bad_n, commit_now;
  logic [1:0] r, c;
  logic [3:0] digit;
  logic valid, is_letter, is_star, is_hash;
  // Letters are laid out contiguously from 'A'; only the 4-letter PQRS group
  // pushes every later base up by one extra letter.
  function automatic logic [7:0] letter(input logic [3:0] d, input logic [1:0] i);
    return 8'h41 + ({4'd0, d} - 8'd2) * 8'd3 + {7'd0, d > 4'd7} + {6'd0, i};
  endfunction
  assign r = cur_key[7] ? 2'd0 : cur_key[6] ? 2'd1 : cur_key[5] ? 2'd2 : 2'd3;
  assign c = cur_key[3] ? 2'd0 : cur_key[2] ? 2'd1 : cur_key[1] ? 2'd2 : 2'd3;
  assign valid = $onehot(cur_key[7:4]) && $onehot(cur_key[3:0]);
  // The top-left 3x3 block carries the digits 1-9 in reading order.
  assign digit = 4'({2'd0, r}) * 4'd3 + {2'd0, c} + 4'd1;
  assign is_letter = valid && r != 2'd3 && c != 2'd3 && {r, c} != 4'd0;
  assign is_star = valid && {r, c} == 4'd12;
  assign is_hash = valid && {r, c} == 4'd14;
  assign last = (held_key == 4'd7 || held_key == 4'd9) ? 2'd3 : 2'd2;
  assign cand_valid = state == CYCLE;
  always_comb begin
    state_n = state;
    held_n = held_key;
    idx_n = idx;
    cnt_n = idle_cnt;
    commit_n = commit_char;
    cp_n = 1'b0;
    clr_n = 1'b0;
    bad_n = 1'b0;
    commit_now = 1'b0;
    if (strobe) begin
      if (is_letter) begin
        if (state == CYCLE && digit == held_key) idx_n = (idx == last) ? 2'd0 : idx + 2'd1;
        else begin
          state_n = CYCLE;
          held_n = digit;
          idx_n = 2'd0;
        end
        cnt_n = '0;
      end else if (is_star) begin
        state_n = IDLE;
        held_n = 4'd0;
        idx_n = 2'd0;
        cnt_n = '0;
        clr_n = 1'b1;
      end else if (is_hash && state == CYCLE) commit_now = 1'b1;
      else bad_n = 1'b1;
    end else if (TIMED && state == CYCLE) begin
      if (idle_cnt == TERM) commit_now = 1'b1;
      else cnt_n = idle_cnt + CNT_W'(1);
    end
    if (commit_now) begin
      commit_n = cand_char;
      cp_n = 1'b1;
      state_n = IDLE;
      held_n = 4'd0;
      idx_n = 2'd0;
      cnt_n = '0;
    end
    cand_n = (state_n == CYCLE) ? letter(held_n, idx_n) : 8'h00;
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      held_key <= 4'd0;
      idx <= 2'd0;
      idle_cnt <= '0;
      cand_char <= 8'h00;
      commit_char <= 8'h00;
      commit_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      bad_key <= 1'b0;
    end else begin
      state <= state_n;
      held_key <= held_n;
      idx <= idx_n;
      idle_cnt <= cnt_n;
      cand_char <= cand_n;
      commit_char <= commit_n;
      commit_pulse <= cp_n;
      clear_pulse <= clr_n;
      bad_key <= bad_n;
    end
  end
endmodule

// File: tb/tb_multitap_letter_fsm.sv
// tb_multitap_letter_fsm: self-checking bench for multitap_letter_fsm.
module tb_multitap_letter_fsm;
  localparam int TO = 16;
  logic clk = 1'b0, nRst = 1'b1, strobe = 1'b0;
  logic [7:0] cur_key = 8'h00;
  logic [7:0] cand_char, commit_char;
  logic cand_valid, commit_pulse, clear_pulse, bad_key;
  int checks = 0, fails = 0;
  logic m_active, m_cp, m_clr, m_bad;
  logic [7:0] m_key, m_commit;
  int m_taps, m_idle;

  multitap_letter_fsm #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .nRst(nRst), .strobe(strobe), .cur_key(cur_key),
    .cand_char(cand_char), .cand_valid(cand_valid), .commit_char(commit_char),
    .commit_pulse(commit_pulse), .clear_pulse(clear_pulse), .bad_key(bad_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] keychar(input logic [7:0] k);
    string row;
    int ri, ci;
    if ($countones(k[7:4]) != 1 || $countones(k[3:0]) != 1) return 8'h00;
    ri = k[7] ? 0 : k[6] ? 1 : k[5] ? 2 : 3;
    ci = k[3] ? 0 : k[2] ? 1 : k[1] ? 2 : 3;
    case (ri)
      0: row = "123A";
      1: row = "456B";
      2: row = "789C";
      default: row = "*0#D";
    endcase
    return row[ci];
  endfunction

  function automatic string grp(input logic [7:0] k);
    case (k)
      "2": return "ABC";
      "3": return "DEF";
      "4": return "GHI";
      "5": return "JKL";
      "6": return "MNO";
      "7": return "PQRS";
      "8": return "TUV";
      default: return "WXYZ";
    endcase
  endfunction

  function automatic logic [7:0] mcand();
    string g;
    if (!m_active) return 8'h00;
    g = grp(m_key);
    return g[m_taps % g.len()];
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_active <= 1'b0; m_key <= 8'h00; m_taps <= 0; m_idle <= 0;
      m_commit <= 8'h00; m_cp <= 1'b0; m_clr <= 1'b0; m_bad <= 1'b0;
    end else begin
      m_cp <= 1'b0; m_clr <= 1'b0; m_bad <= 1'b0;
      if (strobe) begin
        if (keychar(cur_key) >= "2" && keychar(cur_key) <= "9") begin
          if (m_active && keychar(cur_key) == m_key) m_taps <= m_taps + 1;
          else begin
            m_active <= 1'b1; m_key <= keychar(cur_key); m_taps <= 0;
          end
          m_idle <= 0;
        end else if (keychar(cur_key) == "*") begin
          m_active <= 1'b0; m_clr <= 1'b1; m_idle <= 0;
        end else if (keychar(cur_key) == "#" && m_active) begin
          m_commit <= mcand(); m_cp <= 1'b1; m_active <= 1'b0; m_idle <= 0;
        end else m_bad <= 1'b1;
      end else if (m_active && TO > 0) begin
        if (m_idle + 1 == TO) begin
          m_commit <= mcand(); m_cp <= 1'b1; m_active <= 1'b0; m_idle <= 0;
        end else m_idle <= m_idle + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("cand_char", 32'(cand_char), 32'(mcand()));
    chk("cand_valid", 32'(cand_valid), 32'(m_active));
    chk("commit_char", 32'(commit_char), 32'(m_commit));
    chk("commit_pulse", 32'(commit_pulse), 32'(m_cp));
    chk("clear_pulse", 32'(clear_pulse), 32'(m_clr));
    chk("bad_key", 32'(bad_key), 32'(m_bad));
    checks++;
    if ($countones({commit_pulse, clear_pulse, bad_key}) > 1) begin
      fails++;
      $display("FAIL pulse_onehot: got %b expected at most one high", {commit_pulse, clear_pulse, bad_key});
    end
  end

  task automatic press(input logic [7:0] k);
    @(negedge clk);
    strobe = 1'b1;
    cur_key = k;
    @(negedge clk);
    strobe = 1'b0;
    cur_key = 8'h18;
  endtask

  logic [7:0] seq [5] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h50};
  logic [7:0] bad_codes [6] = '{8'hC4, 8'h14, 8'h88, 8'h00, 8'h11, 8'h83};
  int n;

  initial begin
    #1 nRst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cand_char", 32'(cand_char), 32'h0);
    chk("rst_cand_valid", 32'(cand_valid), 32'h0);
    chk("rst_commit_char", 32'(commit_char), 32'h0);
    @(posedge clk);
    #1 nRst = 1'b1;
    press(8'h84);
    chk("t1_cand", 32'(cand_char), 32'h41);
    chk("t1_valid", 32'(cand_valid), 32'h1);
    press(8'h12);
    chk("t1_commit_char", 32'(commit_char), 32'h41);
    chk("t1_commit_pulse", 32'(commit_pulse), 32'h1);
    chk("t1_valid_after", 32'(cand_valid), 32'h0);
    @(negedge clk);
    chk("t1_pulse_width", 32'(commit_pulse), 32'h0);
    for (int i = 0; i < 5; i++) begin
      press(8'h28);
      chk("t2_cand_seq", 32'(cand_char), 32'(seq[i]));
    end
    press(8'h12);
    chk("t2_commit_char", 32'(commit_char), 32'h50);
    press(8'h84);
    chk("t3_cand_a", 32'(cand_char), 32'h41);
    press(8'h82);
    chk("t3_cand_d", 32'(cand_char), 32'h44);
    chk("t3_no_commit", 32'(commit_pulse), 32'h0);
    press(8'h18);
    chk("t3_clear", 32'(clear_pulse), 32'h1);
    chk("t3_cand_zero", 32'(cand_char), 32'h0);
    chk("t3_commit_kept", 32'(commit_char), 32'h50);
    press(8'h12);
    chk("t4_hash_idle_bad", 32'(bad_key), 32'h1);
    chk("t4_hash_idle_nocommit", 32'(commit_pulse), 32'h0);
    foreach (bad_codes[i]) begin
      press(bad_codes[i]);
      chk("t4_idle_bad", 32'(bad_key), 32'h1);
      chk("t4_idle_valid", 32'(cand_valid), 32'h0);
    end
    press(8'h44);
    foreach (bad_codes[i]) begin
      press(bad_codes[i]);
      chk("t4_cycle_bad", 32'(bad_key), 32'h1);
      chk("t4_cycle_cand", 32'(cand_char), 32'h4A);
    end
    press(8'h44);
    chk("t4_idx_kept", 32'(cand_char), 32'h4B);
    press(8'h18);
    press(8'h22);
    press(8'h22);
    chk("t5_cand_x", 32'(cand_char), 32'h58);
    n = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (commit_pulse) begin
        n = i;
        break;
      end
    end
    chk("t5_timeout_cycles", 32'(n), 32'd16);
    chk("t5_timeout_char", 32'(commit_char), 32'h58);
    press(8'h22);
    press(8'h22);
    repeat (14) @(negedge clk);
    press(8'h22);
    chk("t5_terminal_nocommit", 32'(commit_pulse), 32'h0);
    chk("t5_terminal_cand", 32'(cand_char), 32'h59);
    press(8'h18);
    press(8'h44);
    press(8'h44);
    chk("t6_cand_k", 32'(cand_char), 32'h4B);
    @(posedge clk);
    #2 nRst = 1'b0;
    #1;
    chk("t6_rst_cand", 32'(cand_char), 32'h0);
    chk("t6_rst_valid", 32'(cand_valid), 32'h0);
    chk("t6_rst_commit_char", 32'(commit_char), 32'h0);
    chk("t6_rst_pulses", 32'({commit_pulse, clear_pulse, bad_key}), 32'h0);
    @(posedge clk);
    #1 nRst = 1'b1;
    press(8'h44);
    chk("t6_restart", 32'(cand_char), 32'h4A);
    press(8'h18);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
